// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants for the board I/O harness.
// LED channel modes and reset-sequencer state encoding.
package board_io_pkg;

    localparam logic [1:0] LED_OFF    = 2'b00;
    localparam logic [1:0] LED_DIRECT = 2'b01;
    localparam logic [1:0] LED_BLINK  = 2'b10;
    localparam logic [1:0] LED_DIM    = 2'b11;

    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: clock-enable pulse generator.
// tick is high for one CLK every DIV_COUNT cycles; no derived clocks.
module clk_tick_gen #(
    parameter int DIV_COUNT = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Wrap the divider and flag the terminal count of the next cycle.
    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
        tick_d    = (div_cnt_d == LAST);
    end

    // Divider and registered tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board harness with tick generator, reset sequencer,
// heartbeat and per-channel LED driver.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int DIV_COUNT = 50_000_000,
    parameter int RST_HOLD  = 6,
    parameter int NUM_LED   = 6,
    parameter int PWM_BITS  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   soft_rst_req,
    input  logic [NUM_LED-1:0]     led_in,
    input  logic [2*NUM_LED-1:0]   led_mode,
    input  logic [PWM_BITS-1:0]    pwm_duty,
    output logic                   tick,
    output logic                   sys_rst,
    output logic [NUM_LED-1:0]     led_out,
    output logic                   heartbeat,
    output logic                   rst_led
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

    logic                tick_w;
    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [HW-1:0]       hold_cnt_q;
    logic [HW-1:0]       hold_cnt_d;
    logic                hb_q;
    logic                hb_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [NUM_LED-1:0]  led_q;
    logic [NUM_LED-1:0]  led_d;
    logic                pwm_on;

    clk_tick_gen #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick_w)
    );

    // Reset sequencer: soft request restarts the count ahead of any tick.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (soft_rst_req) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
        end else if (state_q == ST_HOLD && tick_w) begin
            if (hold_cnt_q == HOLD_MAX) begin
                state_d = ST_RUN;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    // Heartbeat toggles on ticks seen in RUN and is cleared on entry to HOLD.
    always_comb begin
        hb_d = hb_q;
        if (state_d == ST_HOLD) begin
            hb_d = 1'b0;
        end else if (state_q == ST_RUN && tick_w) begin
            hb_d = ~hb_q;
        end
    end

    // Free-running PWM phase, independent of tick.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = (pwm_cnt_q < pwm_duty);
    end

    // Per-channel LED mode select, blanked whenever the core is held in reset.
    always_comb begin
        led_d = '0;
        if (state_d == ST_RUN) begin
            for (int i = 0; i < NUM_LED; i++) begin
                case (led_mode[2*i +: 2])
                    LED_OFF:    led_d[i] = 1'b0;
                    LED_DIRECT: led_d[i] = led_in[i];
                    LED_BLINK:  led_d[i] = led_in[i] & hb_d;
                    LED_DIM:    led_d[i] = led_in[i] & pwm_on;
                    default:    led_d[i] = 1'b0;
                endcase
            end
        end
    end

    // State, counters and LED drive registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            hb_q       <= 1'b0;
            pwm_cnt_q  <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            hb_q       <= hb_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_q      <= led_d;
        end
    end

    assign tick      = tick_w;
    assign sys_rst   = (state_q == ST_HOLD);
    assign rst_led   = (state_q == ST_HOLD);
    assign heartbeat = hb_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: vectors, corner sequences and a random run
// checked against an arithmetic model of the harness.
module tb_board_io_ctrl;

    localparam int DIV = 4;
    localparam int RH  = 6;
    localparam int NL  = 6;
    localparam int PB  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          soft_rst_req = 1'b0;
    logic [NL-1:0] led_in = '0;
    logic [2*NL-1:0] led_mode = '0;
    logic [PB-1:0] pwm_duty = '0;
    logic          tick;
    logic          sys_rst;
    logic [NL-1:0] led_out;
    logic          heartbeat;
    logic          rst_led;

    board_io_ctrl #(
        .DIV_COUNT (DIV),
        .RST_HOLD  (RH),
        .NUM_LED   (NL),
        .PWM_BITS  (PB)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .soft_rst_req (soft_rst_req),
        .led_in       (led_in),
        .led_mode     (led_mode),
        .pwm_duty     (pwm_duty),
        .tick         (tick),
        .sys_rst      (sys_rst),
        .led_out      (led_out),
        .heartbeat    (heartbeat),
        .rst_led      (rst_led)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rel   = 0;

    logic [NL-1:0]   p_li;
    logic [2*NL-1:0] p_lm;
    logic [PB-1:0]   p_pd;
    logic            p_soft;

    typedef struct {
        int          cyc;
        bit          tk;
        bit          sr;
        bit          hb;
        logic [NL-1:0] led;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int ticks_upto(int x);
        return (x + 1) / DIV;
    endfunction

    function automatic int release_after(int c);
        int t = c + 1;
        while (t % DIV != DIV - 1) t++;
        return t + RH * DIV + 1;
    endfunction

    function automatic bit exp_hb(int n);
        if (n < rel) return 1'b0;
        return 1'((ticks_upto(n - 1) - ticks_upto(rel - 1)) & 1);
    endfunction

    function automatic logic [NL-1:0] exp_led(int n);
        logic [NL-1:0] e = '0;
        int ph = (n - 1) % (1 << PB);
        if (n < rel) return e;
        for (int i = 0; i < NL; i++) begin
            case (p_lm[2*i +: 2])
                2'b01: e[i] = p_li[i];
                2'b10: e[i] = p_li[i] & exp_hb(n);
                2'b11: e[i] = p_li[i] & (ph < int'(p_pd));
                default: e[i] = 1'b0;
            endcase
        end
        return e;
    endfunction

    task automatic step();
        p_li   = led_in;
        p_lm   = led_mode;
        p_pd   = pwm_duty;
        p_soft = soft_rst_req;
        @(posedge CLK);
        cyc++;
        #1;
        if (p_soft) rel = release_after(cyc - 1);
        check("tick", tick, (cyc % DIV) == DIV - 1);
        check("sys_rst", sys_rst, cyc < rel);
        check("rst_led", rst_led, cyc < rel);
        check("heartbeat", heartbeat, exp_hb(cyc));
        check("led_out", led_out, exp_led(cyc));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_sys_rst"}, sys_rst, 1);
        check({tag, "_led"}, led_out, 0);
        check({tag, "_hb"}, heartbeat, 0);
        check({tag, "_rst_led"}, rst_led, 1);
    endtask

    task automatic release_rst();
        RST = 1'b0;
        cyc = 0;
        rel = release_after(-1);
    endtask

    task automatic run_table();
        for (int i = 0; i < 10; i++) begin
            while (cyc < tbl[i].cyc) step();
            check("tbl_tick", tick, tbl[i].tk);
            check("tbl_sys_rst", sys_rst, tbl[i].sr);
            check("tbl_hb", heartbeat, tbl[i].hb);
            check("tbl_led", led_out, tbl[i].led);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int c0;
        int expc;
        bit prev;
        bit dropped;

        tbl[0] = '{2,  0, 1, 0, 6'h00};
        tbl[1] = '{3,  1, 1, 0, 6'h00};
        tbl[2] = '{4,  0, 1, 0, 6'h00};
        tbl[3] = '{7,  1, 1, 0, 6'h00};
        tbl[4] = '{27, 1, 1, 0, 6'h00};
        tbl[5] = '{28, 0, 0, 0, 6'h3f};
        tbl[6] = '{31, 1, 0, 0, 6'h3f};
        tbl[7] = '{32, 0, 0, 1, 6'h3f};
        tbl[8] = '{35, 1, 0, 1, 6'h3f};
        tbl[9] = '{36, 0, 0, 0, 6'h3f};

        led_mode = 12'h555;
        led_in   = 6'h3f;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("por");
        release_rst();
        run_table();

        // DIM duty sweep on channel 0
        led_mode = 12'h003;
        led_in   = 6'h01;
        for (int d = 0; d < 3; d++) begin
            pwm_duty = (d == 0) ? 4'd5 : (d == 1) ? 4'd0 : 4'd15;
            step();
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                cnt += int'(led_out[0]);
            end
            check("dim_count", cnt,
                  (d == 0) ? 5 : (d == 1) ? 0 : 15);
        end

        // BLINK on channel 1
        led_mode = 12'h008;
        led_in   = 6'h02;
        step();
        prev = led_out[1];
        cnt  = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out[1] != prev) cnt++;
            prev = led_out[1];
        end
        check("blink_toggles", cnt, 4);
        led_in = 6'h00;
        step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt += int'(led_out[1]);
        end
        check("blink_off", cnt, 0);

        // Mixed modes, DIRECT channel toggling
        led_mode = 12'h0e4;
        pwm_duty = 4'd8;
        for (int k = 0; k < 20; k++) begin
            led_in = (k % 2 == 0) ? 6'h0f : 6'h0d;
            step();
        end

        // Soft reset coincident with tick, then restart during HOLD
        while (cyc % DIV != DIV - 1) step();
        c0 = cyc;
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("soft_sys_rst", sys_rst, 1);
        repeat (10) step();
        c0 = cyc;
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        expc = c0 + (DIV - 1 - (c0 % DIV)) + ((c0 % DIV == DIV - 1) ? DIV : 0)
               + RH * DIV + 1;
        dropped = 1'b0;
        for (int k = 0; k < 60 && !dropped; k++) begin
            step();
            if (!sys_rst) begin
                dropped = 1'b1;
                check("soft_release_cycle", cyc, expc);
            end
        end
        if (!dropped) check("soft_release_timeout", 0, 1);

        // Random traffic with occasional soft requests
        for (int k = 0; k < 300; k++) begin
            led_in       = NL'($urandom());
            led_mode     = 12'($urandom());
            pwm_duty     = PB'($urandom());
            soft_rst_req = ($urandom_range(0, 49) == 0);
            step();
        end
        soft_rst_req = 1'b0;

        // Asynchronous reset between edges
        led_mode = 12'h555;
        led_in   = 6'h3f;
        step();
        #2 RST = 1'b1;
        #1;
        check_reset_vals("async");
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("async_hold");
        release_rst();
        run_table();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Board-level harness block between the raw board clock/reset and a synthesised core plus its indicator LEDs. It generalises the fixed testbench glue into a parametrised unit with four pieces:
- a clock-enable tick generator, replacing the derived-clock divider;
- a tick-counted system-reset sequencer with soft-reset request;
- an N-channel LED driver with per-channel off/direct/blink/dim modes;
- status outputs for reset and heartbeat.

The core runs on CLK and gates its activity with `tick`; no derived clocks.

## Interface
Parameters:
- DIV_COUNT, 50_000_000: CLK cycles per tick period; legal range ≥ 2.
- RST_HOLD, 6: ticks counted before sys_rst releases; legal range ≥ 1.
- NUM_LED, 6: LED channel count; legal range ≥ 1.
- PWM_BITS, 4: dim-mode PWM counter width.

Ports:
- CLK  in  1  single clock for the whole block.
- RST  in  1  asynchronous, active-high reset.
- soft_rst_req  in  1  single-cycle request to re-run the reset sequence.
- led_in  in  NUM_LED  per-channel LED data from the core.
- led_mode  in  2*NUM_LED  channel i mode in bits [2i+1:2i].
- pwm_duty  in  PWM_BITS  shared dim duty.
- tick  out  1  one-CLK pulse every DIV_COUNT cycles.
- sys_rst  out  1  synchronous-release reset to the core.
- led_out  out  NUM_LED  registered LED drive.
- heartbeat  out  1  blink phase.
- rst_led  out  1  copy of sys_rst.

## Operation
Reset state while RST is high:
- All counters = 0.
- tick = 0, sys_rst = 1, led_out = 0, heartbeat = 0, rst_led = 1.
- FSM = HOLD.

Tick generator:
- div_cnt has $clog2(DIV_COUNT) bits and counts 0..DIV_COUNT-1, then wraps to 0.
- tick is registered and high in the cycle where div_cnt == DIV_COUNT-1.

Reset sequencer, FSM {HOLD, RUN}:
- HOLD:
  - sys_rst = 1.
  - On each tick, hold_cnt increments while hold_cnt < RST_HOLD.
  - On a tick with hold_cnt == RST_HOLD, go to RUN. sys_rst = 0 from the next cycle. Release therefore follows RST_HOLD+1 ticks.
- RUN:
  - sys_rst = 0.
  - soft_rst_req = 1 forces HOLD with hold_cnt = 0 and sys_rst = 1 next cycle.
- soft_rst_req in HOLD restarts the count: hold_cnt = 0, taking priority over a coincident tick.
- hold_cnt width is $clog2(RST_HOLD+1).

Heartbeat:
- Toggles on every tick while in RUN; held at 0 in HOLD.

LED modes (constants from the package):
- 00 OFF: 0.
- 01 DIRECT: led_in[i].
- 10 BLINK: led_in[i] & heartbeat.
- 11 DIM: led_in[i] & (pwm_cnt < pwm_duty).
- pwm_cnt is a free-running PWM_BITS counter that advances every CLK, independent of tick. Its comparison is unsigned.
- duty 0 gives always-off; the maximum is (2^PWM_BITS − 1)/2^PWM_BITS. Full brightness uses DIRECT.

LED gating:
- led_out is forced to 0 whenever sys_rst = 1.
- led_out is registered with one cycle of latency from led_in, led_mode and pwm_duty.

## Timing
- Cycle n = the cycle after the n-th rising CLK edge following RST deassertion.
- tick is high in cycles DIV_COUNT-1, 2·DIV_COUNT-1, …
- sys_rst falls in cycle (RST_HOLD+1)·DIV_COUNT.
- RST assertion clears all outputs immediately, with no clock required. Deassertion takes effect at the next edge.
- soft_rst_req in RUN: sys_rst = 1 one cycle later. div_cnt and pwm_cnt are not disturbed, so tick phase is preserved.
- A mode change is visible on led_out one cycle after the input change.

## Structure
- Package board_io_pkg holds:
  - localparams LED_OFF/LED_DIRECT/LED_BLINK/LED_DIM (2-bit);
  - FSM state encoding ST_HOLD/ST_RUN.
- Sub-module clk_tick_gen (parameter DIV_COUNT; ports CLK, RST, tick) is reusable by other board harnesses.
- Everything else stays in board_io_ctrl.

## Test plan
Unless stated, parameters are DIV_COUNT=4, RST_HOLD=6, NUM_LED=6, PWM_BITS=4.

1. Release RST after 3 cycles → tick high in cycles 3, 7, 11, …; sys_rst and rst_led stay 1 through cycle 27 and are 0 from cycle 28. LEDs are 0 throughout HOLD.
2. Assert RST asynchronously mid-RUN, between edges → sys_rst = 1 and led_out = 0 before the next edge. After release, the full 28-cycle sequence repeats.
3. Pulse soft_rst_req in RUN in the same cycle as tick → HOLD with hold_cnt = 0 and sys_rst = 1 next cycle. Release comes 7 ticks later and tick phase is unchanged. A second request during HOLD restarts the count.
4. Channel 0 in DIM, led_in = 1, pwm_duty = 5 → led_out[0] high for exactly 5 of every 16 cycles.
   - duty 0 → always 0.
   - duty 15 → high 15 of every 16 cycles.
5. Channel 1 in BLINK, led_in = 1 → led_out[1] toggles every 4 cycles (period 8) in phase with heartbeat. Setting led_in = 0 → constant 0.
6. Per-channel modes OFF/DIRECT/BLINK/DIM on channels 0–3 with DIRECT led_in toggling → each channel follows its own mode with one-cycle latency, and no cross-channel interference.
